// File: rtl/awgn_pkg.sv
// Shared constants and LFSR helpers for the complex AWGN channel model.
// Sigma entries are round(256*sqrt(1/(2*10^(k/10)))) for k = 0..15 dB.
package awgn_pkg;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam int LFSR_STEPS = 8;
    localparam int BYTE_MEAN_SUM = 510;

    typedef logic [7:0] sigma_t;

    localparam sigma_t SIGMA_LUT [16] = '{
        8'd181, 8'd161, 8'd144, 8'd128,
        8'd114, 8'd102, 8'd91, 8'd81,
        8'd72, 8'd64, 8'd57, 8'd51,
        8'd45, 8'd41, 8'd36, 8'd32
    };

    function automatic logic [31:0] lfsr_step(
        input logic [31:0] s
    );
        return s[0] ? (s >> 1) ^ LFSR_POLY : s >> 1;
    endfunction

    function automatic logic [31:0] lfsr_adv(
        input logic [31:0] s
    );
        logic [31:0] t;
        t = s;
        for (int k = 0; k < LFSR_STEPS; k++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    function automatic logic [9:0] byte_sum(
        input logic [31:0] s
    );
        return 10'(s[7:0]) + 10'(s[15:8])
             + 10'(s[23:16]) + 10'(s[31:24]);
    endfunction

endpackage

// File: rtl/awgn_channel_iq_if.sv
// I/Q stream bundle: input side with per-sample controls, output side.
// The DUT is the slave; the producer/consumer pair is the master.
interface awgn_channel_iq_if #(
    parameter int DATA_W = 24
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_i;
    logic signed [DATA_W-1:0] x_q;
    logic [3:0]               snr_db;
    logic [2:0]               atten_shift;
    logic                     noise_en;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y_i;
    logic signed [DATA_W-1:0] y_q;

    modport master (
        output in_valid, x_i, x_q, snr_db,
        output atten_shift, noise_en, out_ready,
        input  in_ready, out_valid, y_i, y_q
    );

    modport slave (
        input  in_valid, x_i, x_q, snr_db,
        input  atten_shift, noise_en, out_ready,
        output in_ready, out_valid, y_i, y_q
    );
endinterface

// File: rtl/gauss_noise_gen.sv
// LFSR-driven approximate Gaussian source: 8-step advance per sample,
// then four-byte sum re-centred to zero mean (CLT of uniform bytes).
module gauss_noise_gen
    import awgn_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    input  logic               load,
    output logic signed [10:0] n
);

    logic [31:0] lfsr;
    logic [9:0]  u;

    always_comb u = byte_sum(lfsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
            n    <= '0;
        end else begin
            if (step) lfsr <= lfsr_adv(lfsr);
            if (load) n <= 11'({1'b0, u}) - 11'(BYTE_MEAN_SUM);
        end
    end

endmodule

// File: rtl/awgn_channel_iq.sv
// Complex AWGN channel: attenuate, add scaled I/Q noise, saturate.
// Three-stage pipeline that advances as one unit under backpressure.
module awgn_channel_iq
    import awgn_pkg::*;
#(
    parameter int          DATA_W    = 24,
    parameter int          NOISE_RSH = 0,
    parameter logic [31:0] SEED_I    = 32'hACE1_2468,
    parameter logic [31:0] SEED_Q    = 32'h1357_BDF1
) (
    input  logic        clk,
    input  logic        reset,
    awgn_channel_iq_if.slave bus,
    output logic        sat_flag,
    output logic [31:0] sample_cnt
);

    localparam int SW = DATA_W + 1;

    logic adv, acc;
    logic v1, v2;
    logic ne1, ne2;
    sigma_t sg1, sg2;
    logic signed [DATA_W-1:0] xa1_i, xa1_q;
    logic signed [DATA_W-1:0] xa2_i, xa2_q;
    logic signed [10:0] n_i, n_q;
    logic signed [19:0] p_i, p_q, nz_i, nz_q;
    logic signed [SW-1:0] s_i, s_q;
    logic cl_i, cl_q;

    assign adv = !bus.out_valid || bus.out_ready;
    assign acc = bus.in_valid && adv;
    assign bus.in_ready = adv;

    gauss_noise_gen #(.SEED(SEED_I)) u_gen_i (
        .clk(clk), .reset(reset),
        .step(acc), .load(adv), .n(n_i)
    );

    gauss_noise_gen #(.SEED(SEED_Q)) u_gen_q (
        .clk(clk), .reset(reset),
        .step(acc), .load(adv), .n(n_q)
    );

    function automatic logic signed [DATA_W-1:0] clamp(
        input logic signed [SW-1:0] s
    );
        if (s[SW-1] == s[SW-2]) return s[DATA_W-1:0];
        if (s[SW-1]) return {1'b1, {(DATA_W-1){1'b0}}};
        return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    // sigma is unsigned, so widen it with a zero sign bit
    always_comb begin
        p_i  = 20'(n_i) * 20'($signed({1'b0, sg2}));
        p_q  = 20'(n_q) * 20'($signed({1'b0, sg2}));
        nz_i = ne2 ? (p_i >>> NOISE_RSH) : '0;
        nz_q = ne2 ? (p_q >>> NOISE_RSH) : '0;
        s_i  = SW'(xa2_i) + SW'(nz_i);
        s_q  = SW'(xa2_q) + SW'(nz_q);
        cl_i = s_i[SW-1] != s_i[SW-2];
        cl_q = s_q[SW-1] != s_q[SW-2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y_i       <= '0;
            bus.y_q       <= '0;
            sat_flag      <= 1'b0;
            sample_cnt    <= '0;
        end else begin
            if (acc) sample_cnt <= sample_cnt + 32'd1;
            if (adv) begin
                v1            <= bus.in_valid;
                v2            <= v1;
                bus.out_valid <= v2;
                if (bus.in_valid) begin
                    xa1_i <= bus.x_i >>> bus.atten_shift;
                    xa1_q <= bus.x_q >>> bus.atten_shift;
                    sg1   <= SIGMA_LUT[bus.snr_db];
                    ne1   <= bus.noise_en;
                end
                if (v1) begin
                    xa2_i <= xa1_i;
                    xa2_q <= xa1_q;
                    sg2   <= sg1;
                    ne2   <= ne1;
                end
                if (v2) begin
                    bus.y_i <= clamp(s_i);
                    bus.y_q <= clamp(s_q);
                    if (cl_i || cl_q) sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule
